// File: rtl/opendap_swd_pkg.sv
// Shared SWD host definitions: ACK codes, FSM states and request-byte layout.
// Also provides a helper that assembles the 8-bit request header.
package opendap_swd_pkg;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  localparam int REQ_START = 0;
  localparam int REQ_APNDP = 1;
  localparam int REQ_RNW   = 2;
  localparam int REQ_A2    = 3;
  localparam int REQ_A3    = 4;
  localparam int REQ_PAR   = 5;
  localparam int REQ_STOP  = 6;
  localparam int REQ_PARK  = 7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LRESET,
    ST_REQ,
    ST_TRN_RX,
    ST_ACK,
    ST_TRN_TX,
    ST_WDATA,
    ST_RDATA,
    ST_TRN_END,
    ST_TAIL
  } swd_state_t;

  function automatic logic [7:0] build_req(input logic ap_ndp, input logic r_nw,
                                           input logic [1:0] addr);
    logic [7:0] req;
    req            = '0;
    req[REQ_START] = 1'b1;
    req[REQ_APNDP] = ap_ndp;
    req[REQ_RNW]   = r_nw;
    req[REQ_A2]    = addr[0];
    req[REQ_A3]    = addr[1];
    req[REQ_PAR]   = ap_ndp ^ r_nw ^ addr[0] ^ addr[1];
    req[REQ_STOP]  = 1'b0;
    req[REQ_PARK]  = 1'b1;
    return req;
  endfunction

endpackage

// File: rtl/opendap_swd_host_if.sv
// Command/response bus between an SWD caller (master) and the SWD host (slave).
interface opendap_swd_host_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_line_reset;
  logic        cmd_ap_ndp;
  logic        cmd_r_nw;
  logic [1:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_rdata;
  logic        rsp_parity_err;

  modport master (
    output cmd_valid, cmd_line_reset, cmd_ap_ndp, cmd_r_nw, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_parity_err
  );

  modport slave (
    input  cmd_valid, cmd_line_reset, cmd_ap_ndp, cmd_r_nw, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_parity_err
  );
endinterface

// File: rtl/opendap_swd_clkgen.sv
// SWCLK generator: DIV cycles low then DIV cycles high per bit while run is set.
// bit_sample flags the edge that raises SWCLK, bit_drive the edge that starts the next low phase.
module opendap_swd_clkgen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic swclk,
  output logic bit_drive,
  output logic bit_sample
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_reg;
  logic          swclk_reg;
  logic          phase_end;

  assign phase_end  = run && (cnt_reg == CW'(DIV - 1));
  assign bit_sample = phase_end && !swclk_reg;
  assign bit_drive  = phase_end && swclk_reg;
  assign swclk      = swclk_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      swclk_reg <= 1'b0;
    end else if (!run) begin
      cnt_reg   <= '0;
      swclk_reg <= 1'b0;
    end else if (phase_end) begin
      cnt_reg   <= '0;
      swclk_reg <= ~swclk_reg;
    end else begin
      cnt_reg   <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/opendap_swd_host.sv
// SWD host: serialises one DP/AP read, write or line reset per command and
// reports ACK, read data and read parity status through the response strobe.
module opendap_swd_host
  import opendap_swd_pkg::*;
#(
  parameter int DIV             = 2,
  parameter int IDLE_BITS       = 8,
  parameter int LINE_RESET_BITS = 56
) (
  input  logic               clk,
  input  logic               rst,
  output logic               swclk_o,
  output logic               swdo,
  output logic               swdo_en,
  input  logic               swdi,
  opendap_swd_host_if.slave  bus
);

  localparam int CNT_MAX = ((LINE_RESET_BITS > IDLE_BITS) ? LINE_RESET_BITS : IDLE_BITS) + 2;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  swd_state_t       state_reg, state_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic             swdo_reg, swdo_next;
  logic             swdo_en_reg, swdo_en_next;
  logic [7:0]       req_reg, req_next;
  logic             r_nw_reg, r_nw_next;
  logic [32:0]      wdata_reg, wdata_next;
  logic [32:0]      rx_reg, rx_next;
  logic [2:0]       ack_reg, ack_next;
  logic             rsp_valid_reg, rsp_valid_next;
  logic [2:0]       rsp_ack_reg, rsp_ack_next;
  logic [31:0]      rsp_rdata_reg, rsp_rdata_next;
  logic             rsp_parity_err_reg, rsp_parity_err_next;

  logic run, bit_drive, bit_sample, read_ok;

  assign run     = (state_reg != ST_IDLE);
  assign read_ok = (ack_reg == ACK_OK) && r_nw_reg;

  opendap_swd_clkgen #(.DIV(DIV)) u_clkgen (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .swclk      (swclk_o),
    .bit_drive  (bit_drive),
    .bit_sample (bit_sample)
  );

  assign swdo               = swdo_reg;
  assign swdo_en            = swdo_en_reg;
  assign bus.cmd_ready      = (state_reg == ST_IDLE);
  assign bus.rsp_valid      = rsp_valid_reg;
  assign bus.rsp_ack        = rsp_ack_reg;
  assign bus.rsp_rdata      = rsp_rdata_reg;
  assign bus.rsp_parity_err = rsp_parity_err_reg;

  always_comb begin
    state_next          = state_reg;
    bit_cnt_next        = bit_cnt_reg;
    swdo_next           = swdo_reg;
    swdo_en_next        = swdo_en_reg;
    req_next            = req_reg;
    r_nw_next           = r_nw_reg;
    wdata_next          = wdata_reg;
    rx_next             = rx_reg;
    ack_next            = ack_reg;
    rsp_valid_next      = 1'b0;
    rsp_ack_next        = rsp_ack_reg;
    rsp_rdata_next      = rsp_rdata_reg;
    rsp_parity_err_next = rsp_parity_err_reg;

    case (state_reg)
      ST_IDLE: begin
        bit_cnt_next = '0;
        swdo_next    = 1'b0;
        swdo_en_next = 1'b1;
        if (bus.cmd_valid) begin
          // First bit is either a line-reset one or the request start bit.
          swdo_next = 1'b1;
          if (bus.cmd_line_reset) begin
            state_next = ST_LRESET;
          end else begin
            state_next = ST_REQ;
            req_next   = build_req(bus.cmd_ap_ndp, bus.cmd_r_nw, bus.cmd_addr);
            r_nw_next  = bus.cmd_r_nw;
            wdata_next = {^bus.cmd_wdata, bus.cmd_wdata};
            rx_next    = '0;
            ack_next   = '0;
          end
        end
      end

      ST_LRESET: if (bit_drive) begin
        if (bit_cnt_reg == CNT_W'(LINE_RESET_BITS + 1)) begin
          state_next          = ST_IDLE;
          swdo_next           = 1'b0;
          rsp_valid_next      = 1'b1;
          rsp_ack_next        = '0;
          rsp_rdata_next      = '0;
          rsp_parity_err_next = 1'b0;
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
          swdo_next    = (bit_cnt_reg < CNT_W'(LINE_RESET_BITS - 1));
        end
      end

      ST_REQ: if (bit_drive) begin
        if (bit_cnt_reg == CNT_W'(7)) begin
          state_next   = ST_TRN_RX;
          bit_cnt_next = '0;
          swdo_next    = 1'b0;
          swdo_en_next = 1'b0;
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
          req_next     = {1'b0, req_reg[7:1]};
          swdo_next    = req_reg[1];
        end
      end

      ST_TRN_RX: if (bit_drive) state_next = ST_ACK;

      ST_ACK: begin
        if (bit_sample) ack_next = {swdi, ack_reg[2:1]};
        if (bit_drive) begin
          if (bit_cnt_reg == CNT_W'(2)) begin
            bit_cnt_next = '0;
            if (ack_reg != ACK_OK) state_next = ST_TRN_END;
            else if (r_nw_reg)     state_next = ST_RDATA;
            else                   state_next = ST_TRN_TX;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end

      ST_RDATA: begin
        if (bit_sample) rx_next = {swdi, rx_reg[32:1]};
        if (bit_drive) begin
          if (bit_cnt_reg == CNT_W'(32)) begin
            state_next   = ST_TRN_END;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end

      ST_TRN_TX: if (bit_drive) begin
        state_next   = ST_WDATA;
        swdo_next    = wdata_reg[0];
        swdo_en_next = 1'b1;
      end

      ST_WDATA: if (bit_drive) begin
        if (bit_cnt_reg == CNT_W'(32)) begin
          state_next   = ST_TAIL;
          bit_cnt_next = '0;
          swdo_next    = 1'b0;
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
          wdata_next   = {1'b0, wdata_reg[32:1]};
          swdo_next    = wdata_reg[1];
        end
      end

      ST_TRN_END: if (bit_drive) begin
        state_next   = ST_TAIL;
        bit_cnt_next = '0;
        swdo_next    = 1'b0;
        swdo_en_next = 1'b1;
      end

      ST_TAIL: if (bit_drive) begin
        if (bit_cnt_reg == CNT_W'(IDLE_BITS - 1)) begin
          state_next          = ST_IDLE;
          rsp_valid_next      = 1'b1;
          rsp_ack_next        = ack_reg;
          rsp_rdata_next      = read_ok ? rx_reg[31:0] : 32'h0;
          rsp_parity_err_next = read_ok ? (rx_reg[32] ^ (^rx_reg[31:0])) : 1'b0;
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= ST_IDLE;
      bit_cnt_reg        <= '0;
      swdo_reg           <= 1'b0;
      swdo_en_reg        <= 1'b1;
      req_reg            <= '0;
      r_nw_reg           <= 1'b0;
      wdata_reg          <= '0;
      rx_reg             <= '0;
      ack_reg            <= '0;
      rsp_valid_reg      <= 1'b0;
      rsp_ack_reg        <= '0;
      rsp_rdata_reg      <= '0;
      rsp_parity_err_reg <= 1'b0;
    end else begin
      state_reg          <= state_next;
      bit_cnt_reg        <= bit_cnt_next;
      swdo_reg           <= swdo_next;
      swdo_en_reg        <= swdo_en_next;
      req_reg            <= req_next;
      r_nw_reg           <= r_nw_next;
      wdata_reg          <= wdata_next;
      rx_reg             <= rx_next;
      ack_reg            <= ack_next;
      rsp_valid_reg      <= rsp_valid_next;
      rsp_ack_reg        <= rsp_ack_next;
      rsp_rdata_reg      <= rsp_rdata_next;
      rsp_parity_err_reg <= rsp_parity_err_next;
    end
  end

endmodule

// File: tb/tb_opendap_swd_host.sv
// Directed bench for opendap_swd_host with a bit-level SW-DP target model
// that records every SWCLK rising edge and answers ACK/read-data bits.
module tb_opendap_swd_host;
  import opendap_swd_pkg::*;

  localparam int DIV       = 2;
  localparam int IDLE_BITS = 8;
  localparam int LRB       = 56;
  localparam int BIT_CLK   = 2 * DIV;
  localparam int TRACE_N   = 2048;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic swclk_o, swdo, swdo_en;
  logic swdi = 1'b1;

  opendap_swd_host_if bus_if();

  opendap_swd_host #(.DIV(DIV), .IDLE_BITS(IDLE_BITS), .LINE_RESET_BITS(LRB)) dut (
    .clk     (clk),
    .rst     (rst),
    .swclk_o (swclk_o),
    .swdo    (swdo),
    .swdo_en (swdo_en),
    .swdi    (swdi),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int trace_n = 0;
  int trace_base = 0;
  int rsp_count = 0;
  logic trace_do [0:TRACE_N-1];
  logic trace_en [0:TRACE_N-1];

  logic [2:0]  m_ack = 3'b001;
  logic [31:0] m_rdata = 32'h0;
  logic        m_read = 1'b0;
  logic        m_corrupt = 1'b0;

  // Target answer for bit n of the current transaction (0 = request start bit).
  function automatic logic model_bit(input int n);
    if (n >= 9 && n <= 11) return m_ack[n-9];
    if (m_ack == 3'b001 && m_read && n >= 12 && n <= 43) return m_rdata[n-12];
    if (m_ack == 3'b001 && m_read && n == 44) return (^m_rdata) ^ m_corrupt;
    return 1'b1;
  endfunction

  always @(posedge swclk_o) begin
    if (trace_n < TRACE_N) begin
      trace_do[trace_n] = swdo;
      trace_en[trace_n] = swdo_en;
    end
    trace_n = trace_n + 1;
  end

  always @(negedge swclk_o) swdi = model_bit(trace_n - trace_base);

  always @(negedge clk) if (bus_if.rsp_valid === 1'b1) rsp_count = rsp_count + 1;

  function automatic logic [31:0] wire_bits(input int start, input int len);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v[i] = trace_do[trace_base + start + i];
    return v;
  endfunction

  function automatic int do_count(input int start, input int len);
    int c;
    c = 0;
    for (int i = 0; i < len; i++) if (trace_do[trace_base + start + i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int en_count(input int start, input int len);
    int c;
    c = 0;
    for (int i = 0; i < len; i++) if (trace_en[trace_base + start + i] === 1'b1) c++;
    return c;
  endfunction

  task automatic issue(input logic lr, input logic ap, input logic rnw,
                       input logic [1:0] addr, input logic [31:0] wdata);
    int guard;
    guard = 0;
    while (bus_if.cmd_ready !== 1'b1 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (bus_if.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready: cmd_ready=%b required 1", bus_if.cmd_ready);
    end
    m_read                = rnw;
    trace_base            = trace_n;
    bus_if.cmd_line_reset = lr;
    bus_if.cmd_ap_ndp     = ap;
    bus_if.cmd_r_nw       = rnw;
    bus_if.cmd_addr       = addr;
    bus_if.cmd_wdata      = wdata;
    bus_if.cmd_valid      = 1'b1;
    @(posedge clk); #1;
    bus_if.cmd_valid      = 1'b0;
    // Scramble fields after acceptance; the host must use its captured copy.
    bus_if.cmd_line_reset = ~lr;
    bus_if.cmd_ap_ndp     = ~ap;
    bus_if.cmd_r_nw       = ~rnw;
    bus_if.cmd_addr       = ~addr;
    bus_if.cmd_wdata      = ~wdata;
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (cycles < 5000) begin
      @(posedge clk); #1;
      cycles++;
      if (bus_if.rsp_valid === 1'b1) break;
    end
    checks++;
    if (bus_if.rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", bus_if.rsp_valid, cycles);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({swclk_o, swdo, swdo_en, bus_if.cmd_ready, bus_if.rsp_valid} !== 5'b00110) begin
      failures++;
      $display("FAIL reset_ctrl: swclk,swdo,swdo_en,ready,rsp_valid=%b required 00110",
               {swclk_o, swdo, swdo_en, bus_if.cmd_ready, bus_if.rsp_valid});
    end
    checks++;
    if (bus_if.rsp_ack !== 3'b000 || bus_if.rsp_rdata !== 32'h0 || bus_if.rsp_parity_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp: ack=%b rdata=%h perr=%b required 000 00000000 0",
               bus_if.rsp_ack, bus_if.rsp_rdata, bus_if.rsp_parity_err);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (swclk_o !== 1'b0 || bus_if.cmd_ready !== 1'b1 || trace_n !== 0) begin
      failures++;
      $display("FAIL idle_quiet: swclk=%b ready=%b edges=%0d required 0 1 0",
               swclk_o, bus_if.cmd_ready, trace_n);
    end
  endtask

  task automatic test_dp_read();
    int cyc;
    m_ack = 3'b001; m_rdata = 32'h0BC12477; m_corrupt = 1'b0;
    issue(1'b0, 1'b0, 1'b1, 2'd0, 32'h0);
    wait_rsp(cyc);
    checks++;
    if (wire_bits(0, 8) !== 32'hA5) begin
      failures++; $display("FAIL read_req: got %h required a5", wire_bits(0, 8));
    end
    checks++;
    if (en_count(0, 8) !== 8 || en_count(8, 38) !== 0) begin
      failures++;
      $display("FAIL read_oe: req_en=%0d rx_en=%0d required 8 0", en_count(0, 8), en_count(8, 38));
    end
    checks++;
    if (bus_if.rsp_ack !== 3'b001 || bus_if.rsp_rdata !== 32'h0BC12477 || bus_if.rsp_parity_err !== 1'b0) begin
      failures++;
      $display("FAIL read_rsp: ack=%b rdata=%h perr=%b required 001 0bc12477 0",
               bus_if.rsp_ack, bus_if.rsp_rdata, bus_if.rsp_parity_err);
    end
    // 46 protocol bits (184 clk at DIV=2) followed by the idle tail.
    checks++;
    if (cyc !== (46 + IDLE_BITS) * BIT_CLK || trace_n - trace_base !== 46 + IDLE_BITS) begin
      failures++;
      $display("FAIL read_len: cycles=%0d bits=%0d required %0d %0d",
               cyc, trace_n - trace_base, (46 + IDLE_BITS) * BIT_CLK, 46 + IDLE_BITS);
    end
    checks++;
    if (do_count(46, IDLE_BITS) !== 0 || en_count(46, IDLE_BITS) !== IDLE_BITS) begin
      failures++;
      $display("FAIL read_tail: ones=%0d en=%0d required 0 %0d",
               do_count(46, IDLE_BITS), en_count(46, IDLE_BITS), IDLE_BITS);
    end
  endtask

  task automatic test_ack_wait();
    int cyc;
    m_ack = 3'b010; m_rdata = 32'hFFFF_FFFF; m_corrupt = 1'b0;
    issue(1'b0, 1'b1, 1'b1, 2'd1, 32'h0);
    wait_rsp(cyc);
    checks++;
    if (wire_bits(0, 8) !== 32'hAF) begin
      failures++; $display("FAIL wait_req: got %h required af", wire_bits(0, 8));
    end
    checks++;
    if (bus_if.rsp_ack !== 3'b010 || bus_if.rsp_rdata !== 32'h0 || bus_if.rsp_parity_err !== 1'b0) begin
      failures++;
      $display("FAIL wait_rsp: ack=%b rdata=%h perr=%b required 010 00000000 0",
               bus_if.rsp_ack, bus_if.rsp_rdata, bus_if.rsp_parity_err);
    end
    checks++;
    if (cyc !== (13 + IDLE_BITS) * BIT_CLK || trace_n - trace_base !== 13 + IDLE_BITS) begin
      failures++;
      $display("FAIL wait_len: cycles=%0d bits=%0d required %0d %0d",
               cyc, trace_n - trace_base, (13 + IDLE_BITS) * BIT_CLK, 13 + IDLE_BITS);
    end
    checks++;
    if (en_count(8, 5) !== 0 || en_count(13, IDLE_BITS) !== IDLE_BITS || do_count(13, IDLE_BITS) !== 0) begin
      failures++;
      $display("FAIL wait_oe: trn_en=%0d tail_en=%0d tail_ones=%0d required 0 %0d 0",
               en_count(8, 5), en_count(13, IDLE_BITS), do_count(13, IDLE_BITS), IDLE_BITS);
    end
  endtask

  task automatic test_dp_write();
    int cyc;
    m_ack = 3'b001; m_corrupt = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 2'd2, 32'h01000010);
    wait_rsp(cyc);
    checks++;
    if (wire_bits(0, 8) !== 32'hB1) begin
      failures++; $display("FAIL write_req: got %h required b1", wire_bits(0, 8));
    end
    checks++;
    if (en_count(8, 5) !== 0 || en_count(13, 33) !== 33) begin
      failures++;
      $display("FAIL write_oe: trn_en=%0d data_en=%0d required 0 33", en_count(8, 5), en_count(13, 33));
    end
    checks++;
    if (wire_bits(13, 32) !== 32'h01000010 || trace_do[trace_base + 45] !== 1'b0) begin
      failures++;
      $display("FAIL write_data: got %h par=%b required 01000010 0",
               wire_bits(13, 32), trace_do[trace_base + 45]);
    end
    checks++;
    if (do_count(46, IDLE_BITS) !== 0 || en_count(46, IDLE_BITS) !== IDLE_BITS) begin
      failures++;
      $display("FAIL write_tail: ones=%0d en=%0d required 0 %0d",
               do_count(46, IDLE_BITS), en_count(46, IDLE_BITS), IDLE_BITS);
    end
    checks++;
    if (bus_if.rsp_ack !== 3'b001 || cyc !== (46 + IDLE_BITS) * BIT_CLK) begin
      failures++;
      $display("FAIL write_rsp: ack=%b cycles=%0d required 001 %0d",
               bus_if.rsp_ack, cyc, (46 + IDLE_BITS) * BIT_CLK);
    end
  endtask

  task automatic test_parity_error();
    int cyc;
    m_ack = 3'b001; m_rdata = 32'h00000001; m_corrupt = 1'b1;
    issue(1'b0, 1'b1, 1'b1, 2'd3, 32'h0);
    wait_rsp(cyc);
    checks++;
    if (bus_if.rsp_ack !== 3'b001 || bus_if.rsp_rdata !== 32'h00000001 || bus_if.rsp_parity_err !== 1'b1) begin
      failures++;
      $display("FAIL parity_err: ack=%b rdata=%h perr=%b required 001 00000001 1",
               bus_if.rsp_ack, bus_if.rsp_rdata, bus_if.rsp_parity_err);
    end
    m_corrupt = 1'b0;
  endtask

  task automatic test_line_reset();
    int cyc;
    issue(1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
    wait_rsp(cyc);
    checks++;
    if (trace_n - trace_base !== LRB + 2 || do_count(0, LRB) !== LRB || do_count(LRB, 2) !== 0) begin
      failures++;
      $display("FAIL lreset_bits: bits=%0d ones=%0d trailing_ones=%0d required %0d %0d 0",
               trace_n - trace_base, do_count(0, LRB), do_count(LRB, 2), LRB + 2, LRB);
    end
    checks++;
    if (en_count(0, LRB + 2) !== LRB + 2) begin
      failures++; $display("FAIL lreset_oe: en=%0d required %0d", en_count(0, LRB + 2), LRB + 2);
    end
    checks++;
    if (bus_if.rsp_ack !== 3'b000 || bus_if.rsp_parity_err !== 1'b0 || cyc !== (LRB + 2) * BIT_CLK) begin
      failures++;
      $display("FAIL lreset_rsp: ack=%b perr=%b cycles=%0d required 000 0 %0d",
               bus_if.rsp_ack, bus_if.rsp_parity_err, cyc, (LRB + 2) * BIT_CLK);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    m_ack = 3'b001; m_rdata = 32'h12345678; m_corrupt = 1'b0;
    issue(1'b0, 1'b1, 1'b1, 2'd0, 32'h0);
    wait_rsp(cyc);
    checks++;
    if (bus_if.rsp_rdata !== 32'h12345678) begin
      failures++; $display("FAIL b2b_read: rdata=%h required 12345678", bus_if.rsp_rdata);
    end
    // Still inside the rsp_valid cycle: the next command is accepted at once.
    issue(1'b0, 1'b1, 1'b0, 2'd1, 32'hCAFE0001);
    checks++;
    if (bus_if.rsp_valid !== 1'b0 || bus_if.cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: rsp_valid=%b ready=%b required 0 0", bus_if.rsp_valid, bus_if.cmd_ready);
    end
    wait_rsp(cyc);
    checks++;
    if (wire_bits(13, 32) !== 32'hCAFE0001 || bus_if.rsp_ack !== 3'b001 || cyc !== (46 + IDLE_BITS) * BIT_CLK) begin
      failures++;
      $display("FAIL b2b_write: data=%h ack=%b cycles=%0d required cafe0001 001 %0d",
               wire_bits(13, 32), bus_if.rsp_ack, cyc, (46 + IDLE_BITS) * BIT_CLK);
    end
  endtask

  task automatic test_reset_abort();
    int guard;
    int base_count;
    int cyc;
    m_ack = 3'b001; m_corrupt = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 2'd1, 32'hDEADBEEF);
    guard = 0;
    while (trace_n - trace_base < 20 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    checks++;
    if (trace_n - trace_base < 20) begin
      failures++; $display("FAIL abort_reach: bits=%0d required >=20", trace_n - trace_base);
    end
    @(negedge clk); #1;
    base_count = rsp_count;
    rst = 1'b1;
    #1;
    checks++;
    if ({swclk_o, swdo, swdo_en, bus_if.cmd_ready, bus_if.rsp_valid} !== 5'b00110 || bus_if.rsp_ack !== 3'b000) begin
      failures++;
      $display("FAIL abort_outputs: swclk,swdo,swdo_en,ready,rsp_valid=%b ack=%b required 00110 000",
               {swclk_o, swdo, swdo_en, bus_if.cmd_ready, bus_if.rsp_valid}, bus_if.rsp_ack);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (rsp_count !== base_count) begin
      failures++; $display("FAIL abort_no_rsp: rsp pulses=%0d required %0d", rsp_count, base_count);
    end
    m_rdata = 32'h0BC12477;
    issue(1'b0, 1'b0, 1'b1, 2'd0, 32'h0);
    wait_rsp(cyc);
    checks++;
    if (wire_bits(0, 8) !== 32'hA5 || bus_if.rsp_ack !== 3'b001 || bus_if.rsp_rdata !== 32'h0BC12477) begin
      failures++;
      $display("FAIL abort_recover: req=%h ack=%b rdata=%h required a5 001 0bc12477",
               wire_bits(0, 8), bus_if.rsp_ack, bus_if.rsp_rdata);
    end
  endtask

  initial begin
    bus_if.cmd_valid      = 1'b0;
    bus_if.cmd_line_reset = 1'b0;
    bus_if.cmd_ap_ndp     = 1'b0;
    bus_if.cmd_r_nw       = 1'b0;
    bus_if.cmd_addr       = 2'd0;
    bus_if.cmd_wdata      = 32'h0;
    test_reset();
    test_dp_read();
    test_ack_wait();
    test_dp_write();
    test_parity_error();
    test_line_reset();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/opendap_swd_host.md
Name: opendap_swd_host

Overview:
- SWD host (probe-side initiator) that generates SWCLK and serialises DP/AP transfers toward an SW-DP target.
- Accepts one command at a time: a DP/AP read, a DP/AP write, or a line reset.
- Returns the ACK, the read data and the read-data parity status for each transfer.
- Used as the bench driver for the DP, and as the core of an on-chip debug bridge.

Parameters:
- DIV, 2, clk cycles per SWCLK half-period (must be ≥1).
- IDLE_BITS, 8, idle (low) bits driven after each transfer.
- LINE_RESET_BITS, 56, ones driven for a line reset (must be ≥50).

Ports:
- clk  in  1  block clock
- rst  in  1  asynchronous active-high reset
- swclk_o  out  1  SWCLK to target
- swdo  out  1  SWDIO output data
- swdo_en  out  1  SWDIO output enable
- swdi  in  1  SWDIO input
- cmd_valid  in  1  command present
- cmd_ready  out  1  host idle, command accepted when valid&&ready
- cmd_line_reset  in  1  1 = line reset, 0 = transfer
- cmd_ap_ndp  in  1  APnDP
- cmd_r_nw  in  1  RnW
- cmd_addr  in  2  A[3:2]
- cmd_wdata  in  32  write data
- rsp_valid  out  1  single-cycle response strobe
- rsp_ack  out  3  received ACK, bit0 = first bit on the wire
- rsp_rdata  out  32  read data
- rsp_parity_err  out  1  read-data parity mismatch

Behaviour:
- Interface: one clock `clk`; asynchronous active-high reset `rst`.
- Reset values: swclk_o=0, swdo=0, swdo_en=1, cmd_ready=1, rsp_valid=0, rsp_ack=0, rsp_rdata=0, rsp_parity_err=0, FSM in IDLE.
- Reset asserted mid-operation aborts immediately to these values; no rsp_valid is produced for the aborted command.
- Bit timing:
  - Each bit lasts 2*DIV clk cycles: swclk_o is low for DIV cycles, then high for DIV cycles.
  - swdo/swdo_en update on the clk edge that starts the low phase.
  - swdi is sampled on the clk edge where swclk_o rises.
  - In IDLE, swclk_o is held low and the bit counter is cleared.
- Handshake:
  - cmd_ready=1 only in IDLE; deasserts the cycle after acceptance.
  - The first bit starts on the cycle after acceptance.
  - Command fields are captured at acceptance; later changes to the inputs are ignored.
- FSM states: IDLE, LRESET, REQ, TRN_RX, ACK, TRN_TX, WDATA, RDATA, TRN_END, TAIL.
- LRESET: drive LINE_RESET_BITS ones, then 2 zeros (swdo_en=1), then go to IDLE.
  - rsp_valid pulses at the end with rsp_ack=0 and rsp_parity_err=0.
- REQ: 8 bits, LSB first: start=1, APnDP, RnW, A2, A3, parity (even over the preceding four fields), stop=0, park=1.
- TRN_RX: 1 bit with swdo_en=0; then ACK samples 3 bits (swdo_en=0).
- ACK==3'b001 (OK):
  - Read: RDATA samples 32 data bits LSB first, then 1 parity bit. rsp_parity_err = parity != ^data. Then TRN_END, 1 bit with swdo_en=0.
  - Write: TRN_TX (1 bit, swdo_en=0), then WDATA drives 32 bits LSB first plus even parity.
- Any other ACK (WAIT 010, FAULT 100, protocol error incl. 111):
  - One TRN_END bit, then TAIL; no data phase.
  - rsp_rdata = 0, rsp_parity_err = 0.
- TAIL: IDLE_BITS zeros with swdo_en=1.
- Response timing: rsp_valid pulses one cycle on entry to IDLE after TAIL. rsp_* fields stay stable until the next rsp_valid.
- Retries on WAIT are the caller's responsibility.
- Cycle counts at DIV=2:
  - OK read occupies 46 bits = 184 clk.
  - OK write occupies 46 bits = 184 clk.
  - A non-OK ACK occupies 13+IDLE_BITS bits.
- An accept arriving in the same cycle as rsp_valid is legal; the new command begins immediately after.

Decomposition:
- Shared package opendap_swd_pkg holds:
  - ACK encodings (ACK_OK=3'b001, ACK_WAIT=3'b010, ACK_FAULT=3'b100);
  - FSM state enumeration;
  - request-bit field positions.
- Natural sub-module: opendap_swd_clkgen. It provides the DIV counter, swclk_o, and single-cycle strobes bit_drive (start of low phase) and bit_sample (rising edge), gated by a run enable.

Test Plan:
- DP read DPIDR (ap_ndp=0, r_nw=1, addr=0) with the target model returning OK and 0x0BC12477 → request byte on wire 0xA5, rsp_ack=3'b001, rsp_rdata=0x0BC12477, rsp_parity_err=0, total 184 clk at DIV=2.
- DP write SELECT (addr=2) with 0x01000010 → request 0xB1, trn bit with swdo_en=0, 32 data bits then parity=0, then 8 idle zeros; model captures 0x01000010.
- AP read with the model returning WAIT (010) → no data phase, rsp_ack=3'b010, rsp_rdata=0, cmd_ready back after 13+8 bits.
- Read with the model corrupting the parity bit on data 0x00000001 → rsp_parity_err=1, rsp_rdata=0x00000001.
- Line reset → exactly 56 consecutive ones then 2 zeros, swdo_en=1 throughout, rsp_ack=0.
- Assert rst mid-WDATA → all outputs return to reset values asynchronously, no rsp_valid. The next DPIDR read completes normally.
